fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the instruction buffer entry count (legal 2..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request present.
REQ-006 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 SHALL have port imem_resp_valid  input  1  response data present (in order, one per accepted request, latency at least 1 cycle).
REQ-009 SHALL have port imem_resp_data  input  32  instruction word.
REQ-010 SHALL have port redirect  input  1  jump/branch taken; single-cycle pulse.
REQ-011 SHALL have port redirect_pc  input  32  new fetch address.
REQ-012 SHALL have port if_valid  output  1  instruction available to decode.
REQ-013 SHALL have port if_instr  output  32  instruction at buffer head.
REQ-014 SHALL have port if_pc  output  32  address of if_instr.
REQ-015 SHALL have port if_pcplus4  output  32  if_pc + 4 (mod 2^32).
REQ-016 SHALL have port if_ready  input  1  decode consumes the head this cycle when if_valid=1.

Function
REQ-017 SHALL hold fetch_pc; imem_req_addr = fetch_pc; fetch_pc[1:0] always 0.
REQ-018 SHALL assert imem_req_valid iff occupancy + outstanding < DEPTH (credit rule; buffer never overflows).
REQ-019 SHALL, on an imem_req_valid & imem_req_ready handshake, increment outstanding and set fetch_pc = fetch_pc + 4 (wrap 32'hFFFF_FFFC -> 0).
REQ-020 SHALL record each accepted request address in an in-order address queue paired with its response.
REQ-021 SHALL, on imem_resp_valid with drop_cnt = 0, push {imem_resp_data, queued address} into the buffer and decrement outstanding.
REQ-022 SHALL, on imem_resp_valid with drop_cnt > 0, discard the response and decrement drop_cnt and outstanding.
REQ-023 SHALL ignore imem_resp_valid when outstanding = 0 (protocol error, no state change).
REQ-024 SHALL present the buffer head combinationally on if_instr/if_pc/if_pcplus4; if_valid = (occupancy != 0).
REQ-025 SHALL pop the head on if_valid & if_ready; pop and push in the same cycle leave occupancy unchanged.
REQ-026 SHALL make response-to-if_valid latency exactly 1 cycle with an empty buffer (no combinational bypass).
REQ-027 SHALL, on redirect: empty the buffer, set fetch_pc = {redirect_pc[31:2], 2'b00}, and set drop_cnt = outstanding after this cycle's updates (a request accepted in the redirect cycle is stale and counted; a response arriving that cycle is discarded).
REQ-028 SHALL give redirect priority over push and pop in the same cycle; a head consumed in the redirect cycle counts as consumed.
REQ-029 SHALL issue requests to the new fetch_pc from the cycle after redirect, concurrently with draining stale responses.
REQ-030 SHALL hold imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0, except on redirect.
REQ-031 SHALL hold if_instr/if_pc stable while if_valid=1 and if_ready=0.

Reset
REQ-032 SHALL, while rst=0, force fetch_pc=RESET_PC, occupancy=0, outstanding=0, drop_cnt=0, queues cleared.
REQ-033 SHALL drive imem_req_valid=0, if_valid=0, imem_req_addr=RESET_PC, and if_instr=0, if_pc=0, if_pcplus4=4 during reset.
REQ-034 SHALL assert imem_req_valid in the first clk edge's cycle after rst rises; reset mid-transaction abandons all outstanding requests.

Verification
REQ-035 SHALL test streaming: ready=1 throughout, 1-cycle memory, if_ready=1 -> if_pc sequence 0,4,8,12 back-to-back, if_pcplus4 = if_pc+4.
REQ-036 SHALL test backpressure: if_ready=0 -> at most DEPTH(2) requests issued, then imem_req_valid=0; if_ready=1 -> resumes with 8.
REQ-037 SHALL test redirect with 2 outstanding: redirect_pc=0x40 -> both stale responses dropped, next if_pc=0x40, no 0x8/0xC seen.
REQ-038 SHALL test simultaneous redirect, request handshake and response -> all three stale, next delivered if_pc = redirect target.
REQ-039 SHALL test wrap and alignment: redirect_pc=0xFFFF_FFFB -> if_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-040 SHALL test asynchronous reset mid-stream: rst=0 between edges -> if_valid and imem_req_valid drop immediately; after release the first request is RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order
// address tracking, instruction buffer and redirect with stale-response drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcplus4,
    input  logic        if_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   LIMIT    = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [31:0]   RST_ADDR = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] ib_wr_q, ib_rd_q;
    logic [PW-1:0] aq_wr_q, aq_rd_q;

    logic [31:0] ib_instr_q [DEPTH];
    logic [31:0] ib_pc_q    [DEPTH];
    logic [31:0] aq_addr_q  [DEPTH];

    logic req_fire;
    logic resp_fire;
    logic drop;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Credit rule: buffered plus in-flight never exceeds buffer capacity
    assign imem_req_valid =
        rst & (({1'b0, occ_q} + {1'b0, outst_q}) < LIMIT);
    assign imem_req_addr  = fetch_pc_q;

    assign if_valid   = (occ_q != '0);
    assign if_instr   = if_valid ? ib_instr_q[ib_rd_q] : '0;
    assign if_pc      = if_valid ? ib_pc_q[ib_rd_q] : '0;
    assign if_pcplus4 = if_pc + 32'd4;

    always_comb begin
        req_fire  = imem_req_valid & imem_req_ready;
        resp_fire = imem_resp_valid & (outst_q != '0);
        drop      = resp_fire & (drop_q != '0);
        push      = resp_fire & ~drop & ~redirect;
        pop       = if_valid & if_ready;

        outst_d = outst_q + CW'(req_fire) - CW'(resp_fire);

        if (redirect) begin
            occ_d      = '0;
            drop_d     = outst_d;
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            occ_d      = occ_q + CW'(push) - CW'(pop);
            drop_d     = drop_q - CW'(drop);
            fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RST_ADDR;
            occ_q      <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            ib_wr_q    <= '0;
            ib_rd_q    <= '0;
            aq_wr_q    <= '0;
            aq_rd_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            occ_q      <= occ_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            if (req_fire) begin
                aq_wr_q <= nxt(aq_wr_q);
            end
            if (resp_fire) begin
                aq_rd_q <= nxt(aq_rd_q);
            end
            if (redirect) begin
                ib_wr_q <= '0;
                ib_rd_q <= '0;
            end else begin
                if (push) begin
                    ib_wr_q <= nxt(ib_wr_q);
                end
                if (pop) begin
                    ib_rd_q <= nxt(ib_rd_q);
                end
            end
        end
    end

    // Payload storage needs no reset; validity lives in the counters
    always_ff @(posedge clk) begin
        if (req_fire) begin
            aq_addr_q[aq_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            ib_instr_q[ib_wr_q] <= imem_resp_data;
            ib_pc_q[ib_wr_q]    <= aq_addr_q[aq_rd_q];
        end
    end

endmodule
